double_to_sig16b: RTL and testbench
===================================

# double_to_sig16b

Converts an IEEE-754 double-precision value back into a 16-bit sign-magnitude integer sample (bit 15 sign, bits 14:0 magnitude 0..32767). It sits directly downstream of the floating-point echo-cancellation datapath and is the inverse of the `sig16b_to_double` input stage, feeding the 16-bit sample output. The conversion is iterative: one right-shift per clock, then a rounding/saturation step. An enable/ready handshake surrounds the conversion.

## Interface
- No parameters.
- `clk_operation`  in  1  operation clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  start pulse; sampled only while idle.
- `double`  in  64  IEEE-754 double operand; sampled on the same edge as `enable`.
- `sig16b`  out  16  sign-magnitude result; holds until the next completion.
- `ready`  out  1  single-cycle completion pulse.
- `busy`  out  1  high from the accepting edge until `ready` is asserted.
- `overflow`  out  1  result saturated to 32767; valid with `ready`, held.
- `invalid`  out  1  operand was NaN; valid with `ready`, held.

## Operation
- Field split: S = `double[63]`, E = `double[62:52]`, e = E − 1023, F = `double[51:0]`.
- Working register: mant = {1, F[51:37]} (16 bits). Sticky is seeded as OR of F[36:0].
- Shift count: s = 15 − e, valid for e in −1..14, giving s in 1..16.
- States:
  - IDLE: on `enable`, latch the operand and classify it. A normal operand goes to SHIFT with count s. A special operand goes to ROUND with its result preloaded.
  - SHIFT: each cycle, mant >>= 1. The bit shifted out goes to guard. The old guard is ORed into sticky. The count is decremented. When the count reaches 0, go to ROUND.
  - ROUND: produce the result, set the flags, pulse `ready`, return to IDLE.
- Special classes:
  - E = 0 (zero or denormal), or e < −1: magnitude 0.
  - e > 14, or E = 2047 with F = 0 (infinity): magnitude 32767, `overflow` = 1.
  - E = 2047 with F ≠ 0 (NaN): `sig16b` = 0x0000, `invalid` = 1.
- Output sign is S, except that a zero magnitude always outputs sign 0 (no −0).
- Rounding result of 32768 saturates to 32767 with `overflow` = 1.
- `enable` while `busy` is ignored; the in-flight conversion is unaffected.
- Asserting `rst` mid-conversion aborts it. All outputs return to reset values immediately and no `ready` is issued.

## Timing
- Reset values: `sig16b` = 0x0000, `ready` = 0, `busy` = 0, `overflow` = 0, `invalid` = 0. State is IDLE.
- Edge 0 is the edge that samples `enable` = 1 in IDLE.
- Normal operand: `ready` is high for exactly one cycle after edge s+1, so latency is 2..17 edges.
- Special operand: `ready` is high after edge 1.
- `sig16b` and the flags update on the same edge that raises `ready`.
- `busy` rises after edge 0 and falls on the edge that raises `ready`.
- A new `enable` is accepted on the edge immediately after the one that raised `ready`, i.e. back-to-back operation.
- `enable` coinciding with `rst` release is sampled on the first rising edge after deassertion.

## Configuration
- `DOUBLE_TO_SIG16B_ROUND_EN` defined: the ROUND state applies round-to-nearest, ties away from zero. If guard = 1, magnitude increments; sticky is tracked but not needed for this mode.
- `DOUBLE_TO_SIG16B_ROUND_EN` undefined: truncation toward zero. Guard and sticky are ignored. For e = −1 the result is 0.
- Timing and latency are identical in both builds.

## Test plan
- 0x3FF0000000000000 (1.0) -> `sig16b` = 0x0001, `ready` after edge 16, flags 0.
- 0xC008000000000000 (−3.0) -> 0x8003. 0x8000000000000000 (−0.0) -> 0x0000, latency 1.
- 0x4004000000000000 (2.5) -> 0x0003 with ROUND_EN, 0x0002 without. 0x3FE0000000000000 (0.5) -> 0x0001 with ROUND_EN at edge 17, 0x0000 without.
- 0x40DFFFE000000000 (32767.5) -> 0x7FFF; `overflow` = 1 with ROUND_EN, 0 without.
- 0x40E3880000000000 (40000.0) -> 0x7FFF, `overflow` = 1, latency 1. 0x7FF8000000000000 (NaN) -> 0x0000, `invalid` = 1.
- Second `enable` pulse while `busy` is ignored. `rst` pulse at edge 5 of a 1.0 conversion -> no `ready`, outputs 0, next `enable` converts normally.
- Round trip: 0x1234 through `sig16b_to_double` then this block -> 0x1234.

Source files
------------

// File: rtl/double_to_sig16b.sv
// rtl/double_to_sig16b.sv - IEEE-754 double to 16-bit sign-magnitude sample, one shift per clock.
// DOUBLE_TO_SIG16B_ROUND_EN selects round-to-nearest (ties away); default build truncates.
module double_to_sig16b (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        busy,
  output logic        overflow,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  state_t      state, next_state;
  logic [15:0] mant;
  logic [4:0]  count;
  logic        sign, guard, sticky, sat_pending, nan_pending;

  logic [10:0] exp_field;
  logic [51:0] frac;
  logic        is_nan, is_huge, is_normal;
  logic [15:0] rounded;
  logic        round_ovf;
  logic [14:0] mag;

  assign exp_field = double[62:52];
  assign frac      = double[51:0];
  assign is_nan    = (&exp_field) && (|frac);
  // e > 14 (biased 1037) also covers infinity
  assign is_huge   = (exp_field > 11'd1037) && !is_nan;
  assign is_normal = (exp_field >= 11'd1022) && (exp_field <= 11'd1037);

`ifdef DOUBLE_TO_SIG16B_ROUND_EN
  assign rounded = mant + {15'd0, guard};
`else
  assign rounded = mant;
`endif
  assign round_ovf = rounded[15];
  assign mag       = round_ovf ? 15'h7FFF : rounded[14:0];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = is_normal ? SHIFT : ROUND;
      SHIFT:   if (count == 5'd1) next_state = ROUND;
      ROUND:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      mant        <= 16'd0;
      count       <= 5'd0;
      sign        <= 1'b0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      sat_pending <= 1'b0;
      nan_pending <= 1'b0;
      sig16b      <= 16'd0;
      ready       <= 1'b0;
      overflow    <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      ready <= (state == ROUND);
      case (state)
        IDLE: begin
          if (enable) begin
            sign        <= double[63];
            guard       <= 1'b0;
            sticky      <= |frac[36:0];
            // 15 - e == 1038 - E, which fits in 5 bits for the normal range
            count       <= 5'd14 - exp_field[4:0];
            sat_pending <= is_huge;
            nan_pending <= is_nan;
            if (is_normal)    mant <= {1'b1, frac[51:37]};
            else if (is_huge) mant <= 16'h7FFF;
            else              mant <= 16'd0;
          end
        end
        SHIFT: begin
          mant   <= {1'b0, mant[15:1]};
          guard  <= mant[0];
          sticky <= sticky | guard;
          count  <= count - 5'd1;
        end
        ROUND: begin
          sig16b   <= {sign && (mag != 15'd0), mag};
          overflow <= sat_pending | round_ovf;
          invalid  <= nan_pending;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_sig16b.sv
// tb/tb_double_to_sig16b.sv - table-driven bench for double_to_sig16b.
// Expected values follow DOUBLE_TO_SIG16B_ROUND_EN when it is defined.
module tb_double_to_sig16b;

`ifdef DOUBLE_TO_SIG16B_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] dbl;
  logic [15:0] sig16b;
  logic        ready, busy, overflow, invalid;

  int errors = 0;
  int checks = 0;

  double_to_sig16b dut (
    .clk_operation(clk),
    .rst(rst),
    .enable(enable),
    .double(dbl),
    .sig16b(sig16b),
    .ready(ready),
    .busy(busy),
    .overflow(overflow),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [15:0] s;
    logic        o;
    logic        i;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input logic [63:0] d, input logic [15:0] es, input logic eo, input logic ei,
                         input int el, input string nm, input int glitch);
    int  lat;
    bit  busy_bad;
    @(negedge clk);
    enable = 1'b1;
    dbl    = d;
    @(posedge clk);
    #1;
    chk(busy === 1'b1, {nm, " busy_after_edge0"}, 64'(busy), 64'd1);
    chk(ready === 1'b0, {nm, " ready_low_after_edge0"}, 64'(ready), 64'd0);
    @(negedge clk);
    enable   = 1'b0;
    dbl      = 64'd0;
    lat      = -1;
    busy_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (glitch != 0 && n == glitch) begin
        enable = 1'b1;
        dbl    = 64'h40E3880000000000;
      end else begin
        enable = 1'b0;
      end
    end
    enable = 1'b0;
    chk(lat == el, {nm, " latency"}, 64'(lat), 64'(el));
    chk(!busy_bad, {nm, " busy_held"}, 64'(busy_bad), 64'd0);
    chk(busy === 1'b0, {nm, " busy_low_with_ready"}, 64'(busy), 64'd0);
    chk(sig16b === es, {nm, " sig16b"}, 64'(sig16b), 64'(es));
    chk(overflow === eo, {nm, " overflow"}, 64'(overflow), 64'(eo));
    chk(invalid === ei, {nm, " invalid"}, 64'(invalid), 64'(ei));
  endtask

  initial begin
    int  nvec;
    bit  saw_ready;

    vecs[0]  = '{64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 16, "one"};
    vecs[1]  = '{64'hC008000000000000, 16'h8003, 1'b0, 1'b0, 15, "minus_three"};
    vecs[2]  = '{64'h8000000000000000, 16'h0000, 1'b0, 1'b0, 1,  "minus_zero"};
    vecs[3]  = '{64'h4004000000000000, RND ? 16'h0003 : 16'h0002, 1'b0, 1'b0, 15, "two_point_five"};
    vecs[4]  = '{64'h3FE0000000000000, RND ? 16'h0001 : 16'h0000, 1'b0, 1'b0, 17, "half"};
    vecs[5]  = '{64'hBFE0000000000000, RND ? 16'h8001 : 16'h0000, 1'b0, 1'b0, 17, "minus_half"};
    vecs[6]  = '{64'h40DFFFE000000000, 16'h7FFF, RND, 1'b0, 2, "max_plus_half"};
    vecs[7]  = '{64'hC0DFFFC000000000, 16'hFFFF, 1'b0, 1'b0, 2, "minus_max"};
    vecs[8]  = '{64'h40E3880000000000, 16'h7FFF, 1'b1, 1'b0, 1, "forty_thousand"};
    vecs[9]  = '{64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 1, "nan"};
    vecs[10] = '{64'h3FD0000000000000, 16'h0000, 1'b0, 1'b0, 1, "quarter"};
    vecs[11] = '{64'h40B2340000000000, 16'h1234, 1'b0, 1'b0, 4, "round_trip_1234"};
    vecs[12] = '{64'h8000000000000001, 16'h0000, 1'b0, 1'b0, 1, "neg_denormal"};
    vecs[13] = '{64'hFFF8000000000000, 16'h0000, 1'b0, 1'b1, 1, "neg_nan"};
    vecs[14] = '{64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 16, "one_after_nan"};
    vecs[15] = '{64'hFFF0000000000000, 16'hFFFF, 1'b1, 1'b0, 1, "minus_inf"};
    nvec = 16;

    rst    = 1'b1;
    enable = 1'b0;
    dbl    = 64'd0;
    #1;
    chk(sig16b === 16'd0, "reset sig16b", 64'(sig16b), 64'd0);
    chk({ready, busy, overflow, invalid} === 4'b0000, "reset flags",
        64'({ready, busy, overflow, invalid}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < nvec; k++)
      run_vec(vecs[k].d, vecs[k].s, vecs[k].o, vecs[k].i, vecs[k].lat, vecs[k].nm, 0);

    // overflow must not leak from the previous -inf result, and the busy-time enable is dropped
    run_vec(64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 16, "enable_while_busy", 5);
    run_vec(64'hFFF0000000000000, 16'hFFFF, 1'b1, 1'b0, 1, "minus_inf_again", 0);

    // abort a 1.0 conversion around edge 5
    @(negedge clk);
    enable = 1'b1;
    dbl    = 64'h3FF0000000000000;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(sig16b === 16'd0, "abort sig16b", 64'(sig16b), 64'd0);
    chk({ready, busy, overflow, invalid} === 4'b0000, "abort flags",
        64'({ready, busy, overflow, invalid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1 || busy === 1'b1) saw_ready = 1'b1;
    end
    chk(!saw_ready, "abort no_ready", 64'(saw_ready), 64'd0);

    run_vec(64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 16, "after_abort", 0);
    run_vec(64'h4004000000000000, RND ? 16'h0003 : 16'h0002, 1'b0, 1'b0, 15, "back_to_back", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
